// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback port arbiter.
// Requester indices, FSM state encoding and the hard-wired zero register.
package wb_pkg;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MEM = 1;

  typedef enum logic {
    ST_LAST0 = 1'b0,
    ST_LAST1 = 1'b1
  } wb_state_e;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/wb_rr_pick.sv
// Two-way round-robin picker: grants the sole valid requester, or on a tie
// the one that was not served last. Purely combinational.
module wb_rr_pick
  import wb_pkg::*;
(
  input  logic [1:0] valid,
  input  wb_state_e  last,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned (no latch).
    grant = 2'b00;
    if (valid[REQ_ALU] && (!valid[REQ_MEM] || last == ST_LAST1)) begin
      grant[REQ_ALU] = 1'b1;
    end else if (valid[REQ_MEM]) begin
      grant[REQ_MEM] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between ALU and load writeback,
// registering the winning address/data one cycle after the handshake.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int CW        = 8,
  parameter bit ZERO_SUPP = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          grant_id,
  output logic [CW-1:0] conflict_cnt
);

  wb_state_e     state;
  logic [1:0]    grant;
  logic          xfer;
  logic          win;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          is_zero;

  wb_rr_pick u_pick (
    .valid ({req1_valid, req0_valid}),
    .last  (state),
    .grant (grant)
  );

  // READY is masked during reset so a handshake in a reset cycle never happens.
  assign req0_ready = !rst && grant[REQ_ALU];
  assign req1_ready = !rst && grant[REQ_MEM];

  assign xfer     = req0_ready || req1_ready;
  assign win      = req1_ready;
  assign sel_addr = win ? req1_addr : req0_addr;
  assign sel_data = win ? req1_data : req0_data;
  assign is_zero  = ZERO_SUPP && (sel_addr == AW'(ZERO_REG));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; every register here is small control/datapath
    // state, so all of it is cleared rather than only the control bits.
    if (rst) begin
      state        <= ST_LAST1;
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      grant_id     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      we <= xfer && !is_zero;
      if (xfer) begin
        waddr    <= sel_addr;
        wdata    <= sel_data;
        grant_id <= win;
        state    <= win ? ST_LAST1 : ST_LAST0;
      end
      // Counts contended cycles; saturates instead of wrapping.
      if (req0_valid && req1_valid && conflict_cnt != '1) begin
        conflict_cnt <= conflict_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios then random
// protocol-compliant requesters, checked against a behavioural reference model.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0v, r1v;
  logic [4:0]  r0a, r1a;
  logic [31:0] r0d, r1d;
  logic        r0_ready, r1_ready, we, gid;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [7:0]  cnt;
  logic        s_r0_ready, s_r1_ready, s_we, s_gid;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  wb_port_arbiter u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_addr(r0a), .req0_data(r0d), .req0_ready(r0_ready),
    .req1_valid(r1v), .req1_addr(r1a), .req1_data(r1d), .req1_ready(r1_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .grant_id(gid), .conflict_cnt(cnt)
  );

  wb_port_arbiter #(.CW(2)) u_sat (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_addr(r0a), .req0_data(r0d), .req0_ready(s_r0_ready),
    .req1_valid(r1v), .req1_addr(r1a), .req1_data(r1d), .req1_ready(s_r1_ready),
    .we(s_we), .waddr(s_waddr), .wdata(s_wdata), .grant_id(s_gid), .conflict_cnt(cnt2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who was served last, and what the port should show.
  int          last_srv = 1;
  bit          m_we     = 1'b0;
  logic [4:0]  m_waddr  = '0;
  logic [31:0] m_wdata  = '0;
  bit          m_gid    = 1'b0;
  int          m_cnt    = 0;
  int          m_cnt2   = 0;
  bit          acc0, acc1;
  int          wait0 = 0, wait1 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int pick_winner();
    if (rst) return -1;
    if (r0v && r1v) return (last_srv == 0) ? 1 : 0;
    if (r0v) return 0;
    if (r1v) return 1;
    return -1;
  endfunction

  // One clock: compare everything at the falling edge, advance the model at the
  // rising edge, then return 1 time unit later so the caller can drive inputs.
  task automatic step();
    int w;
    @(negedge clk);
    w = pick_winner();
    check("ready0", r0_ready, w == 0);
    check("ready1", r1_ready, w == 1);
    check("we", we, m_we);
    check("waddr", waddr, m_waddr);
    check("wdata", wdata, m_wdata);
    check("grant_id", gid, m_gid);
    check("conflict_cnt", cnt, m_cnt);
    check("conflict_cnt_cw2", cnt2, m_cnt2);
    @(posedge clk);
    acc0 = (w == 0);
    acc1 = (w == 1);
    if (rst) begin
      last_srv = 1; m_we = 0; m_waddr = '0; m_wdata = '0; m_gid = 0;
      m_cnt = 0; m_cnt2 = 0; wait0 = 0; wait1 = 0;
    end else begin
      if (w >= 0) begin
        m_waddr  = (w == 1) ? r1a : r0a;
        m_wdata  = (w == 1) ? r1d : r0d;
        m_we     = (m_waddr != 0);
        m_gid    = (w == 1);
        last_srv = w;
      end else begin
        m_we = 0;
      end
      if (r0v && r1v) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      wait0 = (r0v && !acc0) ? wait0 + 1 : 0;
      wait1 = (r1v && !acc1) ? wait1 + 1 : 0;
      if (r0v) check("starve0", wait0 > 1, 0);
      if (r1v) check("starve1", wait1 > 1, 0);
    end
    #1;
  endtask

  task automatic refresh_data();
    if (acc0) r0d = $urandom;
    if (acc1) r1d = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    r0v = 0; r1v = 0; r0a = '0; r1a = '0; r0d = '0; r1d = '0;
    @(posedge clk); #1;

    // Reset held with both requesters pending.
    r0v = 1; r0a = 5'd3; r0d = 32'hA000_0000;
    r1v = 1; r1a = 5'd4; r1d = 32'hB000_0000;
    step(); step();
    check("rst_we", we, 0);
    check("rst_cnt", cnt, 0);

    // Tie alternation after release: 0,1,0,1.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("tie_gid", gid, i % 2);
      check("tie_we", we, 1);
      check("tie_waddr", waddr, (i % 2) ? 5'd4 : 5'd3);
      refresh_data();
    end
    check("tie_cnt", cnt, 4);
    r0v = 0; r1v = 0;
    step();

    // Single requester.
    r0v = 1; r0a = 5'd8; r0d = 32'h1234_5678;
    step();
    r0v = 0;
    check("single_we", we, 1);
    check("single_waddr", waddr, 8);
    check("single_wdata", wdata, 32'h1234_5678);
    check("single_gid", gid, 0);
    step();
    check("idle_we", we, 0);
    check("idle_hold_waddr", waddr, 8);

    // Zero-register suppression, then a tie goes to req0.
    r1v = 1; r1a = 5'd0; r1d = 32'hFFFF_FFFF;
    step();
    r1v = 0;
    check("zero_we", we, 0);
    check("zero_gid", gid, 1);
    r0v = 1; r0a = 5'd5; r0d = $urandom;
    r1v = 1; r1a = 5'd6; r1d = $urandom;
    step();
    check("zero_then_tie_gid", gid, 0);
    refresh_data();

    // Reset after the second grant of a burst.
    step();
    check("burst2_gid", gid, 1);
    refresh_data();
    rst = 1'b1;
    step();
    check("midrst_we", we, 0);
    rst = 1'b0;
    step();
    check("after_rst_gid", gid, 0);
    check("after_rst_we", we, 1);
    refresh_data();

    // Saturation of the CW=2 counter, then of the 8-bit counter.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("sat_cw2", cnt2, (i + 1 > 3) ? 3 : i + 1);
      refresh_data();
    end
    for (int i = 0; i < 260; i++) begin
      step();
      refresh_data();
    end
    check("sat_cw8", cnt, 255);

    // Random protocol-compliant requesters with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!r0v || acc0) begin
        r0v = ($urandom_range(0, 3) != 0);
        r0a = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        r0d = $urandom;
      end
      if (!r1v || acc1) begin
        r1v = ($urandom_range(0, 3) != 0);
        r1a = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        r1d = $urandom;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
